// File: rtl/gcd_pkg.sv
// ============================================================================
// Module  : gcd_pkg
// Purpose : Shared types and defaults for the GCD request sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package gcd_pkg;

    localparam int C_N     = 8;
    localparam int C_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ZERO  = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/gcd_req_fifo.sv
// ============================================================================
// Module  : gcd_req_fifo
// Purpose : Synchronous request FIFO with occupancy count; power-of-2 depth.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gcd_req_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]   C_FULL = (C_AW+1)'(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [C_AW-1:0] r_wptr;
    logic [C_AW-1:0] r_rptr;
    logic [C_AW:0]   r_count;
    logic            w_push;
    logic            w_pop;

    // A push at full is accepted only when a pop frees the slot in the same cycle.
    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != C_FULL) || w_pop);

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_count == C_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_sequencer.sv
// ============================================================================
// Module  : gcd_sequencer
// Purpose : Buffers operand pairs, issues them to the GCD engine, returns results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gcd_sequencer
    import gcd_pkg::*;
#(
    parameter int N     = C_N,
    parameter int DEPTH = C_DEPTH
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [N-1:0]            req_a,
    input  logic [N-1:0]            req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N-1:0]            res_data,
    output logic                    gcd_start,
    output logic [N-1:0]            gcd_ina,
    output logic [N-1:0]            gcd_inb,
    input  logic                    gcd_ready,
    input  logic [N-1:0]            gcd_out,
    output logic [$clog2(DEPTH):0]  count
);

    seq_state_t    r_state;
    logic          r_start;
    logic          r_res_valid;
    logic [N-1:0]  r_res_data;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [2*N-1:0] w_head;
    logic [N-1:0]  w_head_a;
    logic [N-1:0]  w_head_b;

    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign w_pop     = (r_state == ISSUE) || (r_state == ZERO);
    assign w_head_a  = w_head[2*N-1:N];
    assign w_head_b  = w_head[N-1:0];

    assign gcd_ina   = w_head_a;
    assign gcd_inb   = w_head_b;
    assign gcd_start = r_start;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

    gcd_req_fifo #(
        .W     (2*N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({req_a, req_b}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_start     <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty && gcd_ready) begin
                        // The engine never terminates on a zero operand, so those pairs bypass it.
                        if ((w_head_a != '0) && (w_head_b != '0)) begin
                            r_state <= ISSUE;
                            r_start <= 1'b1;
                        end else begin
                            r_state <= ZERO;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                ZERO: begin
                    r_res_data  <= w_head_a | w_head_b;
                    r_res_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                WAIT: begin
                    if (gcd_ready) begin
                        r_res_data  <= gcd_out;
                        r_res_valid <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gcd_sequencer.sv
// ============================================================================
// Module  : tb_gcd_sequencer
// Purpose : Scoreboard bench for gcd_sequencer with a behavioural GCD engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gcd_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       gcd_start;
    logic [7:0] gcd_ina;
    logic [7:0] gcd_inb;
    logic       gcd_ready;
    logic [7:0] gcd_out;
    logic [2:0] count;

    logic       rr_manual;
    logic       rr_rand;
    logic       rand_rr;
    assign res_ready = rand_rr ? rr_rand : rr_manual;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         starts = 0;
    int         results = 0;
    int         last_push_cyc = 0;
    logic [7:0] exp_q[$];

    gcd_sequencer #(.N(8), .DEPTH(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .gcd_start (gcd_start),
        .gcd_ina   (gcd_ina),
        .gcd_inb   (gcd_inb),
        .gcd_ready (gcd_ready),
        .gcd_out   (gcd_out),
        .count     (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Subtractive engine: registered ready, one subtraction per busy cycle.
    logic [7:0] e_a;
    logic [7:0] e_b;
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gcd_ready <= 1'b1;
            gcd_out   <= '0;
            e_a       <= '0;
            e_b       <= '0;
        end else if (gcd_start) begin
            e_a       <= gcd_ina;
            e_b       <= gcd_inb;
            gcd_ready <= 1'b0;
        end else if (!gcd_ready) begin
            if (e_a == e_b) begin
                gcd_out   <= e_a;
                gcd_ready <= 1'b1;
            end else if (e_a > e_b) begin
                e_a <= e_a - e_b;
            end else begin
                e_b <= e_b - e_a;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        rr_rand = ($urandom_range(0, 2) != 0);
    end

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[7:0];
    endfunction

    // Monitor: expectations enter at request transfer, leave at result transfer.
    always @(negedge clk) begin
        if (nrst) begin
            if (gcd_start) starts++;
            if (req_valid && req_ready) exp_q.push_back(ref_gcd(req_a, req_b));
            if (res_valid && res_ready) begin
                checks++;
                results++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected actual=%0d required=no result", res_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (res_data !== e) begin
                        errors++;
                        $display("FAIL result_data actual=%0d required=%0d", res_data, e);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the transfer edge.
    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        while (!acc && n < 3000) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                last_push_cyc = cyc;
            end
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_res_valid(output int c);
        int n;
        n = 0;
        c = -1;
        while (n < 3000) begin
            @(negedge clk);
            if (res_valid) begin
                c = cyc;
                break;
            end
            n++;
        end
        if (c < 0) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic drain(input int limit);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !res_valid && (count == 0);
            n++;
        end
        chk("drain_complete", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int s0;
        int r0;
        int n;
        logic [7:0] a;
        logic [7:0] b;
        int r;

        nrst      = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rr_manual = 1'b1;
        rand_rr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_gcd_start", int'(gcd_start), 0);
        chk("rst_res_data", int'(res_data), 0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic issue, hold under back-pressure, release
        rr_manual = 1'b0;
        s0 = starts;
        push_pair(8'd48, 8'd18);
        wait_res_valid(c);
        chk("t1_res_data", int'(res_data), 6);
        repeat (3) @(negedge clk);
        chk("t1_hold_valid", int'(res_valid), 1);
        chk("t1_hold_data", int'(res_data), 6);
        @(posedge clk);
        #1;
        rr_manual = 1'b1;
        @(posedge clk);
        #1;
        rr_manual = 1'b0;
        @(negedge clk);
        chk("t1_valid_dropped", int'(res_valid), 0);
        chk("t1_start_pulses", starts - s0, 1);

        // 2: zero operands resolved locally
        rr_manual = 1'b1;
        @(posedge clk);
        #1;
        s0 = starts;
        push_pair(8'd7, 8'd0);
        r = last_push_cyc;
        wait_res_valid(c);
        chk("t2_zero_latency", c - r, 3);
        @(posedge clk);
        #1;
        push_pair(8'd0, 8'd9);
        push_pair(8'd0, 8'd0);
        drain(200);
        chk("t2_no_start", starts - s0, 0);

        // 3: one-cycle engine busy, latency T+5
        push_pair(8'd5, 8'd5);
        r = last_push_cyc;
        wait_res_valid(c);
        chk("t3_latency", c - r, 5);
        chk("t3_res_data", int'(res_data), 5);
        drain(200);

        // 4: fill FIFO behind a held result
        rr_manual = 1'b0;
        push_pair(8'd48, 8'd18);
        push_pair(8'd100, 8'd75);
        push_pair(8'd81, 8'd27);
        push_pair(8'd17, 8'd5);
        push_pair(8'd64, 8'd48);
        repeat (4) @(negedge clk);
        chk("t4_count_full", int'(count), 4);
        chk("t4_req_ready_full", int'(req_ready), 0);
        @(posedge clk);
        #1;
        req_a = 8'd9;
        req_b = 8'd6;
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_no_push_full", int'(count), 4);
        @(posedge clk);
        #1;
        rr_manual = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gcd_start && n < 100);
        chk("t4_pop_cycle_seen", int'(gcd_start), 1);
        chk("t4_pop_cycle_ready", int'(req_ready), 0);
        chk("t4_pop_cycle_count", int'(count), 4);
        @(posedge clk);
        #1;
        push_pair(8'd9, 8'd6);
        @(negedge clk);
        chk("t4_refilled", int'(count), 4);
        @(posedge clk);
        #1;
        drain(3000);

        // 5: reset during WAIT abandons the in-flight pair
        push_pair(8'd255, 8'd1);
        push_pair(8'd3, 8'd3);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_pre_count", int'(count), 1);
        nrst = 1'b0;
        #1;
        chk("t5_res_valid", int'(res_valid), 0);
        chk("t5_count", int'(count), 0);
        chk("t5_req_ready", int'(req_ready), 1);
        chk("t5_gcd_start", int'(gcd_start), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        push_pair(8'd12, 8'd8);
        wait_res_valid(c);
        chk("t5_after_reset", int'(res_data), 4);
        drain(200);

        // 6: random traffic with consumer stalls
        rand_rr = 1'b1;
        r0 = results;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 7);
            if (r == 0) a = 8'd0;
            if (r == 1) b = 8'd0;
            if (r == 2) begin
                a = 8'd0;
                b = 8'd0;
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
            end
            push_pair(a, b);
        end
        drain(40000);
        chk("t6_result_count", results - r0, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
